// File: rtl/enable_pulse_gen_if.sv
// -----------------------------------------------------------------------------
// enable_pulse_gen_if
//   Groups the button/switch inputs and the strobe/data outputs of the
//   counter control front end.
//
//   Signals:
//     btn     raw count pushbutton (asynchronous, bouncy)
//     ld_btn  raw load pushbutton (asynchronous, bouncy)
//     auto    1 selects periodic count ticks (quasi-static)
//     sw      load value switches, W bits (quasi-static)
//     e       one-cycle count-enable pulse
//     load    one-cycle load strobe
//     data    registered load value, W bits
//
//   Modports:
//     master  stimulus side: drives buttons/switches, observes strobes
//     slave   pulse generator side
// -----------------------------------------------------------------------------
interface enable_pulse_gen_if #(
    parameter int W = 4
);
    logic         btn;
    logic         ld_btn;
    logic         auto;
    logic [W-1:0] sw;
    logic         e;
    logic         load;
    logic [W-1:0] data;

    modport master (
        output btn, ld_btn, auto, sw,
        input  e, load, data
    );

    modport slave (
        input  btn, ld_btn, auto, sw,
        output e, load, data
    );
endinterface

// File: rtl/enable_pulse_gen.sv
// -----------------------------------------------------------------------------
// enable_pulse_gen
//   Control front end for the lab counter. Turns two raw pushbuttons and a
//   free-running prescaler into clean single-cycle count-enable (e) and load
//   strobes, plus a registered load value (data).
//
//   Parameters:
//     DEBOUNCE_CYCLES  consecutive stable synchronized samples needed to accept
//                      a press or a release (>= 2)
//     TICK_DIV         auto-mode tick period in clock cycles (>= 2)
//     W                width of sw/data
//
//   Ports:
//     clk    single clock, rising edge
//     reset  asynchronous, active-low reset
//     bus    enable_pulse_gen_if slave modport (btn, ld_btn, auto, sw in;
//            e, load, data out)
// -----------------------------------------------------------------------------
module enable_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 10,
    parameter int W               = 4
) (
    input  logic               clk,
    input  logic               reset,
    enable_pulse_gen_if.slave  bus
);

    // Debounce FSM encoding
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARM    = 2'd1;
    localparam logic [1:0] S_HELD   = 2'd2;
    localparam logic [1:0] S_DISARM = 2'd3;

    // The stability counter is cleared on the first sample of a new level
    // (the IDLE->ARM or HELD->DISARM transition), so that first sample is
    // already one of the DEBOUNCE_CYCLES. The counter then only has to reach
    // DEBOUNCE_CYCLES-2 before the final accepting sample.
    localparam int             CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

    localparam int             PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

    // -------------------------------------------------------------------------
    // Two-flop synchronizers; bit 0 = btn, bit 1 = ld_btn
    // -------------------------------------------------------------------------
    logic [1:0] raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;

    assign raw = {bus.ld_btn, bus.btn};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, exactly like the hardware.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce FSMs, one per button. press[i] is a combinational one-cycle
    // pulse on the ARM->HELD transition; it is registered in the output stage.
    // -------------------------------------------------------------------------
    logic [1:0] press;

    for (genvar i = 0; i < 2; i++) begin : g_db
        logic [1:0]    state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          press_d;

        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sync2_q[i]) begin
                        state_d = S_ARM;
                        cnt_d   = '0;
                    end
                end
                S_ARM: begin
                    if (!sync2_q[i]) begin
                        state_d = S_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = S_HELD;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_HELD: begin
                    if (!sync2_q[i]) begin
                        state_d = S_DISARM;
                        cnt_d   = '0;
                    end
                end
                S_DISARM: begin
                    // A bounce back high during release is still the same press.
                    if (sync2_q[i]) begin
                        state_d = S_HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign press[i] = press_d;
    end

    // -------------------------------------------------------------------------
    // Prescaler: counts only while auto=1; auto=0 parks it at 0 so the first
    // tick after re-enabling comes a full TICK_DIV period later.
    // -------------------------------------------------------------------------
    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    assign tick = bus.auto && (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q;
        if (!bus.auto) begin
            pre_d = '0;
        end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output merge. A load strobe wins over any coincident enable; that enable
    // is dropped, and the prescaler keeps its own cadence regardless.
    // -------------------------------------------------------------------------
    logic         e_q, e_d;
    logic         load_q, load_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        load_d = press[1];
        e_d    = (press[0] | tick) & ~press[1];
        data_d = press[1] ? bus.sw : data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q    <= 1'b0;
            load_q <= 1'b0;
            data_q <= '0;
        end else begin
            e_q    <= e_d;
            load_q <= load_d;
            data_q <= data_d;
        end
    end

    assign bus.e    = e_q;
    assign bus.load = load_q;
    assign bus.data = data_q;

endmodule

// File: tb/tb_enable_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_enable_pulse_gen
//   Self-checking bench for enable_pulse_gen. Each stimulus step pushes the
//   rising-edge number at which e/load must be seen into a queue; a monitor on
//   the falling edge pops matching entries and compares, and flags any pulse
//   that nothing predicted.
//
//   Edge numbering: edge_cnt is the index of the most recent rising edge. An
//   input driven after a falling edge is first sampled at edge_cnt+1 (= s).
//   A button held high from s pulses at s+DEBOUNCE_CYCLES+1 (6th edge counting
//   s); auto held high from s ticks at s+TICK_DIV-1, then every TICK_DIV.
// -----------------------------------------------------------------------------
module tb_enable_pulse_gen;

    localparam int DB  = 4;
    localparam int TD  = 10;
    localparam int W   = 4;

    typedef struct {
        int           edge_n;
        logic [W-1:0] data;
    } ld_exp_t;

    logic clk;
    logic reset;
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    int      e_q[$];
    ld_exp_t ld_q[$];

    enable_pulse_gen_if #(.W(W)) ifc ();

    enable_pulse_gen #(
        .DEBOUNCE_CYCLES(DB),
        .TICK_DIV       (TD),
        .W              (W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, act, exp, edge_cnt);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (edge_cnt < t) @(negedge clk);
    endtask

    // -------------------------------------------------------------------------
    // Scoreboard monitor
    // -------------------------------------------------------------------------
    bit           exp_e;
    bit           exp_ld;
    logic [W-1:0] exp_data;

    always @(negedge clk) begin
        exp_e    = 1'b0;
        exp_ld   = 1'b0;
        exp_data = '0;
        for (int i = 0; i < e_q.size(); i++) begin
            if (e_q[i] == edge_cnt) begin
                exp_e = 1'b1;
                e_q.delete(i);
                break;
            end
        end
        for (int i = 0; i < ld_q.size(); i++) begin
            if (ld_q[i].edge_n == edge_cnt) begin
                exp_ld   = 1'b1;
                exp_data = ld_q[i].data;
                ld_q.delete(i);
                break;
            end
        end
        if (ifc.e || exp_e)
            check("e_pulse", 32'(ifc.e), 32'(exp_e));
        if (ifc.load || exp_ld)
            check("load_pulse", 32'(ifc.load), 32'(exp_ld));
        if (exp_ld)
            check("load_data", 32'(ifc.data), 32'(exp_data));
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int s;

        // Reset with inputs active
        reset      = 1'b0;
        ifc.btn    = 1'b1;
        ifc.ld_btn = 1'b0;
        ifc.auto   = 1'b1;
        ifc.sw     = W'(9);
        idle(2);
        check("rst_e",    32'(ifc.e),    0);
        check("rst_load", 32'(ifc.load), 0);
        check("rst_data", 32'(ifc.data), 0);
        s = edge_cnt + 1;
        e_q.push_back(s + DB + 1);
        e_q.push_back(s + TD - 1);
        reset = 1'b1;
        wait_until(s + 10);
        ifc.auto = 1'b0;
        ifc.btn  = 1'b0;
        idle(12);

        // Clean press, full re-press, then a too-short release (no pulse)
        s = edge_cnt + 1;
        e_q.push_back(s + DB + 1);
        ifc.btn = 1'b1;
        idle(20);
        ifc.btn = 1'b0;
        idle(8);
        s = edge_cnt + 1;
        e_q.push_back(s + DB + 1);
        ifc.btn = 1'b1;
        idle(10);
        ifc.btn = 1'b0;
        idle(2);
        ifc.btn = 1'b1;
        idle(10);
        ifc.btn = 1'b0;
        idle(10);

        // Bounce: high 3, low 1, high 10
        ifc.btn = 1'b1;
        idle(3);
        ifc.btn = 1'b0;
        idle(1);
        s = edge_cnt + 1;
        e_q.push_back(s + DB + 1);
        ifc.btn = 1'b1;
        idle(10);
        ifc.btn = 1'b0;
        idle(10);

        // Auto tick: 35 on, 20 off, re-enable
        s = edge_cnt + 1;
        e_q.push_back(s + TD - 1);
        e_q.push_back(s + 2 * TD - 1);
        e_q.push_back(s + 3 * TD - 1);
        ifc.auto = 1'b1;
        idle(35);
        ifc.auto = 1'b0;
        idle(20);
        s = edge_cnt + 1;
        e_q.push_back(s + TD - 1);
        ifc.auto = 1'b1;
        idle(12);
        ifc.auto = 1'b0;
        idle(5);

        // Load and data hold
        ifc.sw = W'(7);
        s = edge_cnt + 1;
        ld_q.push_back('{edge_n: s + DB + 1, data: W'(7)});
        ifc.ld_btn = 1'b1;
        idle(10);
        ifc.ld_btn = 1'b0;
        ifc.sw     = W'(3);
        idle(10);
        check("data_hold", 32'(ifc.data), 7);

        // Collision: load on tick (e dropped), button on the next tick (one e)
        ifc.sw = W'(5);
        s = edge_cnt + 1;
        ifc.auto = 1'b1;
        e_q.push_back(s + TD - 1);
        e_q.push_back(s + 3 * TD - 1);
        ld_q.push_back('{edge_n: s + 2 * TD - 1, data: W'(5)});
        wait_until(s + 2 * TD - 1 - DB - 2);
        ifc.ld_btn = 1'b1;
        wait_until(s + 20);
        ifc.ld_btn = 1'b0;
        wait_until(s + 3 * TD - 1 - DB - 2);
        ifc.btn = 1'b1;
        wait_until(s + 31);
        ifc.auto = 1'b0;
        wait_until(s + 33);
        ifc.btn = 1'b0;
        idle(12);

        // Reset mid-ARM with auto running: no pulse, outputs clear at once
        ifc.auto = 1'b1;
        ifc.btn  = 1'b1;
        idle(4);
        reset = 1'b0;
        #1;
        check("midrst_e",    32'(ifc.e),    0);
        check("midrst_load", 32'(ifc.load), 0);
        check("midrst_data", 32'(ifc.data), 0);
        ifc.btn  = 1'b0;
        ifc.auto = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle(15);

        check("e_left",    32'(e_q.size()),  0);
        check("load_left", 32'(ld_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
